// File: rtl/axi_rdata_sfifo.sv
// rtl/axi_rdata_sfifo.sv - Wide-to-narrow R-channel FIFO with per-burst lane extraction
// Stores wide R beats and replays them as narrow beats starting at a commanded sub-word lane.
module axi_rdata_sfifo #(
    parameter int W_WTH      = 64,
    parameter int R_WTH      = 32,
    parameter int DEPTH      = 4,
    parameter int OFFSET_WTH = $clog2(W_WTH / R_WTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [OFFSET_WTH-1:0] cmd_offset,
    input  logic [7:0]            cmd_len,
    input  logic                  wen,
    input  logic [W_WTH-1:0]      wdata,
    input  logic [1:0]            wresp,
    input  logic                  wlast,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  ren,
    output logic [R_WTH-1:0]      rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  empty,
    output logic                  almost_empty,
    output logic                  len_err
);

    localparam int RATIO   = W_WTH / R_WTH;
    localparam int DEPTH_W = $clog2(DEPTH);
    localparam int CNT_W   = DEPTH_W + 1;

    localparam logic [CNT_W-1:0]      CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]      CNT_AFULL = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]      CNT_ZERO  = '0;
    localparam logic [OFFSET_WTH-1:0] SIDX_LAST = OFFSET_WTH'(RATIO - 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [W_WTH-1:0]      r_mem_data [DEPTH];
    logic [1:0]            r_mem_resp [DEPTH];
    logic                  r_mem_last [DEPTH];

    logic [DEPTH_W-1:0]    r_waddr;
    logic [DEPTH_W-1:0]    r_raddr;
    logic [CNT_W-1:0]      r_count;
    logic [OFFSET_WTH-1:0] r_sidx;
    logic [7:0]            r_bcnt;
    logic [7:0]            r_blen;

    logic w_push;
    logic w_pop_beat;
    logic w_pop_entry;
    logic w_cmd_acc;
    logic w_rlast;
    logic w_empty;

    assign full         = (r_count == CNT_FULL);
    assign almost_full  = (r_count >= CNT_AFULL);
    assign almost_empty = (r_count <= CNT_ONE);
    assign w_empty      = (r_count == CNT_ZERO) || (r_state == ST_IDLE);
    assign empty        = w_empty;

    // Gated by !empty so the reset state (bcnt == blen == 0) does not show a spurious last.
    assign w_rlast = !w_empty && (r_bcnt == r_blen);
    assign rlast   = w_rlast;

    assign rdata = r_mem_data[r_raddr][r_sidx*R_WTH +: R_WTH];
    assign rresp = r_mem_resp[r_raddr];

    assign w_push      = wen && !full;
    assign w_pop_beat  = ren && !w_empty;
    assign w_pop_entry = w_pop_beat && (w_rlast || (r_sidx == SIDX_LAST));
    assign w_cmd_acc   = cmd_valid && cmd_ready;

    assign len_err = w_pop_entry && (w_rlast != r_mem_last[r_raddr]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Ready opens in ACTIVE only on the final pop, so the next burst chains without a bubble.
    always_comb begin
        w_state_nxt = r_state;
        cmd_ready   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_state_nxt = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (w_pop_beat && w_rlast) begin
                    cmd_ready   = 1'b1;
                    w_state_nxt = cmd_valid ? ST_ACTIVE : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_waddr] <= wdata;
            r_mem_resp[r_waddr] <= wresp;
            r_mem_last[r_waddr] <= wlast;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_waddr <= '0;
            r_raddr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_waddr <= r_waddr + 1'b1;
            end
            if (w_pop_entry) begin
                r_raddr <= r_raddr + 1'b1;
            end
            if (w_push && !w_pop_entry) begin
                r_count <= r_count + CNT_ONE;
            end else if (!w_push && w_pop_entry) begin
                r_count <= r_count - CNT_ONE;
            end
        end
    end

    // A command accepted on the last pop overrides the lane reset to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sidx <= '0;
            r_bcnt <= '0;
            r_blen <= '0;
        end else begin
            if (w_cmd_acc) begin
                r_sidx <= cmd_offset;
                r_bcnt <= '0;
                r_blen <= cmd_len;
            end else if (w_pop_beat) begin
                r_bcnt <= r_bcnt + 8'd1;
                if (w_pop_entry) begin
                    r_sidx <= '0;
                end else begin
                    r_sidx <= r_sidx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_rdata_sfifo.sv
// tb/tb_axi_rdata_sfifo.sv - Directed self-checking bench for axi_rdata_sfifo
module tb_axi_rdata_sfifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [0:0]  cmd_offset;
    logic [7:0]  cmd_len;
    logic        wen;
    logic [63:0] wdata;
    logic [1:0]  wresp;
    logic        wlast;
    logic        full;
    logic        almost_full;
    logic        ren;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        empty;
    logic        almost_empty;
    logic        len_err;

    int n_vec = 0;
    int n_err = 0;

    axi_rdata_sfifo #(.W_WTH(64), .R_WTH(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_offset(cmd_offset), .cmd_len(cmd_len),
        .wen(wen), .wdata(wdata), .wresp(wresp), .wlast(wlast),
        .full(full), .almost_full(almost_full),
        .ren(ren), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .empty(empty), .almost_empty(almost_empty), .len_err(len_err)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        cmd_valid = 1'b0; cmd_offset = 1'b0; cmd_len = 8'd0;
        wen = 1'b0; wdata = '0; wresp = 2'd0; wlast = 1'b0; ren = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk); rst = 1'b0; #1;
        n_vec++;
        if (cmd_ready !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0 || empty !== 1'b1 ||
            almost_empty !== 1'b1 || rlast !== 1'b0 || len_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs got rdy=%b full=%b af=%b empty=%b ae=%b rlast=%b lerr=%b want 1 0 0 1 1 0 0",
                     cmd_ready, full, almost_full, empty, almost_empty, rlast, len_err);
        end
    endtask

    task automatic test_basic();
        logic [31:0] exp [4];
        exp[0] = 32'h11111111; exp[1] = 32'h22222222; exp[2] = 32'h33333333; exp[3] = 32'h44444444;
        @(negedge clk); cmd_valid = 1'b1; cmd_offset = 1'b0; cmd_len = 8'd3; #1;
        n_vec++;
        if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL basic_cmd_ready got %b want 1", cmd_ready); end
        @(negedge clk); cmd_valid = 1'b0; wen = 1'b1; wdata = 64'h22222222_11111111; wresp = 2'd0; wlast = 1'b0; #1;
        n_vec++;
        if (empty !== 1'b1) begin n_err++; $display("FAIL basic_empty_before_push got %b want 1", empty); end
        @(negedge clk); wdata = 64'h44444444_33333333; wlast = 1'b1; #1;
        n_vec++;
        if (empty !== 1'b0 || rdata !== 32'h11111111) begin
            n_err++; $display("FAIL basic_latency got empty=%b rdata=%h want 0 11111111", empty, rdata);
        end
        @(negedge clk); wen = 1'b0; ren = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            n_vec++;
            if (empty !== 1'b0 || rdata !== exp[i] || rlast !== (i == 3) || len_err !== 1'b0) begin
                n_err++;
                $display("FAIL basic_beat%0d got empty=%b rdata=%h rlast=%b lerr=%b want 0 %h %b 0",
                         i, empty, rdata, rlast, len_err, exp[i], (i == 3));
            end
        end
        @(negedge clk); ren = 1'b0; #1;
        n_vec++;
        if (empty !== 1'b1 || almost_empty !== 1'b1 || cmd_ready !== 1'b1 || full !== 1'b0) begin
            n_err++;
            $display("FAIL basic_drained got empty=%b ae=%b rdy=%b full=%b want 1 1 1 0", empty, almost_empty, cmd_ready, full);
        end
    endtask

    task automatic test_single_offset();
        @(negedge clk); cmd_valid = 1'b1; cmd_offset = 1'b1; cmd_len = 8'd0;
        @(negedge clk); cmd_valid = 1'b0; wen = 1'b1; wdata = 64'hBBBBBBBB_AAAAAAAA; wresp = 2'd2; wlast = 1'b1;
        @(negedge clk); wen = 1'b0; ren = 1'b1; #1;
        n_vec++;
        if (empty !== 1'b0 || rdata !== 32'hBBBBBBBB || rresp !== 2'd2 || rlast !== 1'b1 || len_err !== 1'b0 || cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL single_beat got empty=%b rdata=%h rresp=%0d rlast=%b lerr=%b rdy=%b want 0 bbbbbbbb 2 1 0 1",
                     empty, rdata, rresp, rlast, len_err, cmd_ready);
        end
        @(negedge clk); ren = 1'b0; #1;
        n_vec++;
        if (empty !== 1'b1 || cmd_ready !== 1'b1 || almost_empty !== 1'b1) begin
            n_err++; $display("FAIL single_idle got empty=%b rdy=%b ae=%b want 1 1 1", empty, cmd_ready, almost_empty);
        end
    endtask

    task automatic test_full();
        @(negedge clk); cmd_valid = 1'b1; cmd_offset = 1'b0; cmd_len = 8'd7;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0; wen = 1'b1; wresp = 2'd0;
            wdata = (i == 4) ? 64'hDEADBEEF_DEADBEEF : {32'h30000001 + 32'(2*i), 32'h30000000 + 32'(2*i)};
            wlast = (i == 3);
            #1;
            if (i > 0) begin
                n_vec++;
                if (almost_full !== (i >= 3) || full !== (i >= 4)) begin
                    n_err++;
                    $display("FAIL full_flags_after_%0d got af=%b full=%b want %b %b", i, almost_full, full, (i >= 3), (i >= 4));
                end
            end
        end
        @(negedge clk); wen = 1'b0; #1;
        n_vec++;
        if (full !== 1'b1 || almost_full !== 1'b1) begin
            n_err++; $display("FAIL full_after_drop got full=%b af=%b want 1 1", full, almost_full);
        end
        ren = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            n_vec++;
            if (empty !== 1'b0 || rdata !== 32'h30000000 + 32'(k) || rlast !== (k == 7) || len_err !== 1'b0) begin
                n_err++;
                $display("FAIL full_drain%0d got empty=%b rdata=%h rlast=%b lerr=%b want 0 %h %b 0",
                         k, empty, rdata, rlast, len_err, 32'h30000000 + 32'(k), (k == 7));
            end
        end
        @(negedge clk); ren = 1'b0; #1;
        n_vec++;
        if (empty !== 1'b1 || almost_empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0) begin
            n_err++;
            $display("FAIL full_drained got empty=%b ae=%b full=%b af=%b want 1 1 0 0", empty, almost_empty, full, almost_full);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk); cmd_valid = 1'b1; cmd_offset = 1'b0; cmd_len = 8'd1;
        @(negedge clk); cmd_valid = 1'b0; wen = 1'b1; wdata = 64'hA1A1A1A1_A0A0A0A0; wlast = 1'b1;
        @(negedge clk); wdata = 64'hB1B1B1B1_B0B0B0B0; wlast = 1'b1;
        @(negedge clk); wen = 1'b0; cmd_valid = 1'b1; cmd_offset = 1'b1; cmd_len = 8'd0; ren = 1'b1; #1;
        n_vec++;
        if (cmd_ready !== 1'b0 || rdata !== 32'hA0A0A0A0 || rlast !== 1'b0) begin
            n_err++; $display("FAIL b2b_beat0 got rdy=%b rdata=%h rlast=%b want 0 a0a0a0a0 0", cmd_ready, rdata, rlast);
        end
        @(negedge clk); #1;
        n_vec++;
        if (cmd_ready !== 1'b1 || rdata !== 32'hA1A1A1A1 || rlast !== 1'b1 || len_err !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_beat1 got rdy=%b rdata=%h rlast=%b lerr=%b want 1 a1a1a1a1 1 0", cmd_ready, rdata, rlast, len_err);
        end
        @(negedge clk); cmd_valid = 1'b0; #1;
        n_vec++;
        if (empty !== 1'b0 || rdata !== 32'hB1B1B1B1 || rlast !== 1'b1 || len_err !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_burstB got empty=%b rdata=%h rlast=%b lerr=%b want 0 b1b1b1b1 1 0", empty, rdata, rlast, len_err);
        end
        @(negedge clk); ren = 1'b0; #1;
        n_vec++;
        if (empty !== 1'b1 || almost_empty !== 1'b1) begin
            n_err++; $display("FAIL b2b_drained got empty=%b ae=%b want 1 1", empty, almost_empty);
        end
    endtask

    task automatic test_len_err();
        logic [31:0] exp [3];
        logic        exp_err [3];
        exp[0] = 32'hE000E000; exp[1] = 32'hE001E001; exp[2] = 32'hE010E010;
        exp_err[0] = 1'b0; exp_err[1] = 1'b1; exp_err[2] = 1'b0;
        @(negedge clk); cmd_valid = 1'b1; cmd_offset = 1'b0; cmd_len = 8'd2;
        @(negedge clk); cmd_valid = 1'b0; wen = 1'b1; wdata = 64'hE001E001_E000E000; wlast = 1'b1;
        @(negedge clk); wdata = 64'hE011E011_E010E010; wlast = 1'b1;
        @(negedge clk); wen = 1'b0; ren = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            n_vec++;
            if (empty !== 1'b0 || rdata !== exp[i] || rlast !== (i == 2) || len_err !== exp_err[i]) begin
                n_err++;
                $display("FAIL lenerr_beat%0d got empty=%b rdata=%h rlast=%b lerr=%b want 0 %h %b %b",
                         i, empty, rdata, rlast, len_err, exp[i], (i == 2), exp_err[i]);
            end
        end
        @(negedge clk); ren = 1'b0; #1;
        n_vec++;
        if (empty !== 1'b1 || almost_empty !== 1'b1 || len_err !== 1'b0) begin
            n_err++; $display("FAIL lenerr_drained got empty=%b ae=%b lerr=%b want 1 1 0", empty, almost_empty, len_err);
        end
    endtask

    task automatic test_reset_mid_burst();
        @(negedge clk); cmd_valid = 1'b1; cmd_offset = 1'b0; cmd_len = 8'd3;
        @(negedge clk); cmd_valid = 1'b0; wen = 1'b1; wdata = 64'h22222222_11111111; wlast = 1'b0;
        @(negedge clk); wdata = 64'h44444444_33333333; wlast = 1'b1;
        @(negedge clk); wen = 1'b0; ren = 1'b1; #1;
        n_vec++;
        if (rdata !== 32'h11111111) begin n_err++; $display("FAIL rstmid_beat0 got %h want 11111111", rdata); end
        @(negedge clk); ren = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0; #1;
        n_vec++;
        if (empty !== 1'b1 || full !== 1'b0 || cmd_ready !== 1'b1 || almost_empty !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_state got empty=%b full=%b rdy=%b ae=%b want 1 0 1 1", empty, full, cmd_ready, almost_empty);
        end
        cmd_valid = 1'b1; cmd_offset = 1'b1; cmd_len = 8'd0;
        @(negedge clk); cmd_valid = 1'b0; wen = 1'b1; wdata = 64'h66666666_55555555; wlast = 1'b1; #1;
        n_vec++;
        if (empty !== 1'b1 || cmd_ready !== 1'b0) begin
            n_err++; $display("FAIL rstmid_no_stale got empty=%b rdy=%b want 1 0", empty, cmd_ready);
        end
        @(negedge clk); wen = 1'b0; ren = 1'b1; #1;
        n_vec++;
        if (empty !== 1'b0 || rdata !== 32'h66666666 || rlast !== 1'b1 || len_err !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_replay got empty=%b rdata=%h rlast=%b lerr=%b want 0 66666666 1 0", empty, rdata, rlast, len_err);
        end
        @(negedge clk); ren = 1'b0; #1;
        n_vec++;
        if (empty !== 1'b1 || cmd_ready !== 1'b1) begin
            n_err++; $display("FAIL rstmid_drained got empty=%b rdy=%b want 1 1", empty, cmd_ready);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single_offset();
        test_full();
        test_back_to_back();
        test_len_err();
        test_reset_mid_burst();
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axi_rdata_sfifo.md
Name: axi_rdata_sfifo

Overview:
- Synchronous read-data FIFO with width downsizing for the AXI interconnect read path, the counterpart of the write-data upsizing FIFO.
- Accepts wide R beats (data, resp, last) from the slave-side port and replays them as narrow beats to the master-side port.
- Per-burst commands set the starting sub-word lane and the narrow beat count, so unaligned and short narrow bursts are extracted from wide beats.

Parameters:
- W_WTH, 64, write-side (slave) data width; W_WTH = R_WTH × RATIO, RATIO a power of 2, ≥ 2.
- R_WTH, 32, read-side (master) data width.
- DEPTH, 4, number of wide entries; power of 2, ≥ 2.
- OFFSET_WTH, $clog2(W_WTH/R_WTH), width of the sub-word offset.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  new narrow-burst descriptor valid.
- cmd_ready  out  1  descriptor accepted when cmd_valid & cmd_ready.
- cmd_offset  in  OFFSET_WTH  starting narrow lane in the first wide entry.
- cmd_len  in  8  narrow beats minus 1 (AXI len encoding).
- wen  in  1  push one wide entry; ignored when full.
- wdata  in  W_WTH  wide read data.
- wresp  in  2  RRESP of the wide beat.
- wlast  in  1  RLAST of the wide beat.
- full  out  1  entry count == DEPTH.
- almost_full  out  1  entry count ≥ DEPTH-1.
- ren  in  1  pop one narrow beat; ignored when empty.
- rdata  out  R_WTH  current narrow beat (first-word fall-through).
- rresp  out  2  resp of the current entry.
- rlast  out  1  current narrow beat is the last of the burst.
- empty  out  1  no narrow beat available.
- almost_empty  out  1  entry count ≤ 1.
- len_err  out  1  one-cycle pulse on a wide/narrow last mismatch.

Behaviour:
- Storage: DEPTH × {W_WTH data, 2 resp, 1 last}; waddr/raddr wrap modulo DEPTH; count is DEPTH_W+1 bits.
- Write: wen & !full stores the entry at waddr, waddr+1, count+1. full is evaluated on the current registered count, so a write while full is dropped even if a pop occurs in the same cycle.
- Control FSM:
  - IDLE: cmd_ready=1. On accept: sidx=cmd_offset, bcnt=0, blen=cmd_len, go to ACTIVE.
  - ACTIVE: cmd_ready=1 only in the cycle the final narrow beat pops (ren & !empty & rlast), which allows a zero-bubble chain to the next burst. Without a new cmd in that cycle, go to IDLE.
- empty = (count==0) | (state==IDLE).
- rdata = mem[raddr][sidx*R_WTH +: R_WTH]; rresp = mem[raddr].resp; rlast = (bcnt==blen). These are combinational from registers and valid whenever !empty.
- Narrow pop (ren & !empty):
  - bcnt+1.
  - If rlast or sidx==RATIO-1: pop the entry (raddr+1, count-1), sidx=0. A cmd accepted in the same cycle overrides sidx with cmd_offset.
  - Otherwise: sidx+1, entry retained.
- Simultaneous push and entry pop: count unchanged.
- Latency: wen at cycle N with ACTIVE and count 0 gives empty=0 and valid rdata at N+1.
- len_err pulses in the cycle of an entry pop when:
  - rlast=1 and entry last=0, or
  - entry last=1 and rlast=0.
- In both cases the popped entry is discarded and normal operation continues.
- Reset: all pointers, count, sidx, bcnt, blen cleared; state=IDLE. Outputs: cmd_ready=1, full=0, almost_full=0, empty=1, almost_empty=1, rlast=0 (since bcnt=blen=0 but empty=1, consumers must qualify with !empty), len_err=0. rdata and rresp are don't-care.
- Reset mid-burst drops all stored entries and the active descriptor; no partial beat is emitted afterwards.
- ren while empty and cmd_valid while cmd_ready=0 have no effect.

Test Plan (W_WTH=64, R_WTH=32, DEPTH=4):
1. cmd offset=0 len=3; write {0x22222222_11111111,last=0} then {0x44444444_33333333,last=1}; ren=1 -> rdata 0x11111111, 0x22222222, 0x33333333, 0x44444444; rlast only on the 4th beat; count returns to 0; len_err never asserted.
2. cmd offset=1 len=0; write {0xBBBBBBBB_AAAAAAAA,last=1,resp=2} -> single beat rdata=0xBBBBBBBB, rresp=2, rlast=1; entry popped; empty=1 and state IDLE next cycle.
3. ren=0, cmd active, 5 consecutive writes -> almost_full=1 after the 3rd, full=1 after the 4th, 5th dropped; drain yields exactly 8 beats of the first 4 entries in order.
4. Burst A (len=1) with burst B (offset=1 len=0) cmd_valid held -> cmd_ready=1 only on A's rlast pop; B's beat appears the very next cycle with no empty bubble.
5. cmd offset=0 len=2; entry0 last=1, entry1 last=1 -> len_err pulses when entry0 pops (2nd beat); rlast on the 3rd beat (entry1 lane 0, last=1) pops entry1 with no further len_err.
6. Assert rst for one cycle after the 1st beat of scenario 1 -> next cycle empty=1, full=0, cmd_ready=1, count=0; a new cmd plus write replays correctly from lane cmd_offset.
